exe_stage: RTL
==============

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage ARM-subset pipeline; consumes ID/EX register outputs.
//  Forwards Rn/Rm from MEM/WB, builds Val2 (imm rotate / shift / mem offset), runs ALU.
//  Computes branch target; owns the NZCV status register read by ID condition check.
//  Results go to the EX/MEM register.
// PARAMETERS
//  W        32  datapath width; only 32 is supported
//  SR_W      4  status register width {N,Z,C,V}
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  pcIn           in   32  PC+4 of instruction, from ID/EX
//  aluCmdIn       in   4   ALU command
//  memReadIn      in   1   LDR
//  memWriteIn     in   1   STR
//  sIn            in   1   update status when 1
//  immIn          in   1   I bit: Val2 from rotated imm8
//  shiftOperandIn in   12  shifter operand field
//  imm24In        in   24  signed branch offset (words)
//  regRnIn        in   32  Rn from register file
//  regRmIn        in   32  Rm from register file
//  selSrc1        in   2   Rn fwd select: 00 reg, 01 MEM, 10 WB, 11 reg
//  selSrc2        in   2   Rm fwd select, same encoding
//  memFwdVal      in   32  ALU result in MEM stage
//  wbFwdVal       in   32  write-back value
//  aluResOut      out  32  ALU result / memory address
//  storeValOut    out  32  forwarded Rm (STR data)
//  branchAddrOut  out  32  branch target
//  statusOut      out  4   registered NZCV {N,Z,C,V}
// BEHAVIOUR
//  - Only state: status register. Reset -> statusOut = 4'b0000. All other outputs
//    combinational, zero added latency; during reset they follow inputs.
//  - Forwarding: op1 = mux(selSrc1); rmF = mux(selSrc2); storeValOut = rmF.
//  - Val2 priority: immIn=1 -> ROR({24'b0,imm8=sh[7:0]}, 2*sh[11:8]);
//    else memReadIn|memWriteIn -> {20'b0, sh[11:0]};
//    else shift rmF by sh[11:7], type sh[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
//    Shift amount 0 -> rmF unchanged for all types (no RRX).
//  - ALU (C_in = statusOut[1]):
//    0001 MOV val2 | 1001 MVN ~val2 | 0010 ADD op1+val2 | 0011 ADC op1+val2+C_in
//    0100 SUB op1-val2 | 0101 SBC op1-val2-~C_in | 0110 AND | 0111 ORR | 1000 EOR
//    CMP uses 0100, TST 0110, LDR/STR 0010; others -> result 0, flags 0.
//  - Flags: N=res[31]; Z=(res==0); C = carry-out of 33-bit add, ~borrow for
//    SUB/SBC, 0 for logic/MOV/MVN; V = signed overflow for arith, 0 otherwise.
//  - statusOut <= next flags on posedge when sIn=1 && !rst; else hold.
//    rst dominates sIn in the same cycle. Flushed bubbles arrive with sIn=0.
//  - Back-to-back S instructions: ADC/SBC read statusOut, i.e. flags of the
//    previous S instruction (updated at end of its EX cycle).
//  - branchAddrOut = pcIn + ({{6{imm24[23]}},imm24} << 2), mod 2^32.
//  - All arithmetic mod 2^32; wrap sets C/V per rules, never saturates.
// STRUCTURE
//  - Shared pkg/defines: ALU command codes, shift-type codes, fwd-select codes,
//    NZCV bit indices.
//  - Sub-modules: val2_gen (Val2 mux/shift/rotate, combinational) and alu;
//    status register uses existing Register #(4) with ld=sIn, clr=1'b0.
// TESTING
//  1 rst=1 two cycles, sIn=1 -> statusOut=0000; release, idle -> stays 0000.
//  2 ADD S=1, op1=7FFFFFFF, imm=1 -> aluRes=80000000; next cycle NZCV=1001.
//  3 SUB S=1, Rn=5, Rm=5 LSL #0 -> aluRes=0, NZCV=0110; then ADC Rn=1,Rm=1
//    S=0 -> aluRes=3, status unchanged.
//  4 MOV imm, sh=12'h4FF -> val2=FF000000; MOV Rm=80000000 ASR #4 -> F8000000;
//    ROR #8 on 12345678 -> 78123456.
//  5 selSrc1=01 memFwdVal=10, selSrc2=10 wbFwdVal=20, ADD reg -> aluRes=30,
//    storeValOut=20; STR offset 12'hFFC, op1=1000 -> aluRes=1FFC.
//  6 pcIn=100, imm24=FFFFFE -> branchAddr=F8; imm24=000003 -> 10C;
//    rst and sIn=1 same cycle -> statusOut=0000.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage.
// Purpose: ALU command codes, shifter type codes, forwarding select codes,
// NZCV bit positions and a rotate-right helper used by the Val2 generator.
package exe_stage_pkg;

  localparam int W    = 32;
  localparam int SR_W = 4;

  // ALU commands; CMP shares SUB, TST shares AND, LDR/STR share ADD.
  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;
  localparam logic [3:0] ALU_MVN = 4'b1001;

  // Shift types in shifter operand bits [6:5].
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Forwarding selects for Rn / Rm.
  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
  localparam logic [1:0] FWD_REG2 = 2'b11;

  // NZCV bit indices inside statusOut.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Rotate right by 0..31; a shift of 32 yields zero so n=0 returns x.
  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/Register.sv
// Generic load/clear register.
// Ports: clk, rst (sync active-high), ld (load d), clr (sync clear), d, q.
module Register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // State update: reset and clear dominate load, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (ld) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/exe_stage_alu.sv
// ALU for the execute stage (combinational).
// Ports: aluCmd, op1, val2, cIn (current C flag), result, flags {N,Z,C,V}.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [3:0]  aluCmd,
  input  logic [31:0] op1,
  input  logic [31:0] val2,
  input  logic        cIn,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  logic [32:0] sum_s;
  logic        valid_s;
  logic        c_s;
  logic        v_s;

  // Operation decode; subtraction is op1 + ~val2 + carry so C is ~borrow.
  always_comb begin
    result  = 32'd0;
    sum_s   = 33'd0;
    valid_s = 1'b1;
    c_s     = 1'b0;
    v_s     = 1'b0;
    case (aluCmd)
      ALU_MOV: result = val2;
      ALU_MVN: result = ~val2;
      ALU_ADD, ALU_ADC: begin
        sum_s  = {1'b0, op1} + {1'b0, val2} + {32'd0, (aluCmd == ALU_ADC) & cIn};
        result = sum_s[31:0];
        c_s    = sum_s[32];
        v_s    = (op1[31] == val2[31]) && (result[31] != op1[31]);
      end
      ALU_SUB, ALU_SBC: begin
        sum_s  = {1'b0, op1} + {1'b0, ~val2} + {32'd0, (aluCmd == ALU_SUB) | cIn};
        result = sum_s[31:0];
        c_s    = sum_s[32];
        v_s    = (op1[31] != val2[31]) && (result[31] != op1[31]);
      end
      ALU_AND: result = op1 & val2;
      ALU_ORR: result = op1 | val2;
      ALU_EOR: result = op1 ^ val2;
      default: valid_s = 1'b0;
    endcase
  end

  // Flag assembly; undefined commands report all-zero flags.
  always_comb begin
    flags = 4'b0000;
    if (valid_s) begin
      flags[FLAG_N] = result[31];
      flags[FLAG_Z] = (result == 32'd0);
      flags[FLAG_C] = c_s;
      flags[FLAG_V] = v_s;
    end else begin
      flags = 4'b0000;
    end
  end

endmodule

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator for the execute stage (combinational).
// Ports: immIn (rotated imm8), memAccess (LDR/STR offset), shiftOperand
// (12-bit field), rmFwd (forwarded Rm), val2 (result).
module exe_stage_val2_gen
  import exe_stage_pkg::*;
(
  input  logic        immIn,
  input  logic        memAccess,
  input  logic [11:0] shiftOperand,
  input  logic [31:0] rmFwd,
  output logic [31:0] val2
);

  logic [4:0] shAmt_s;

  assign shAmt_s = shiftOperand[11:7];

  // Val2 selection: immediate beats memory offset beats register shift.
  always_comb begin
    val2 = 32'd0;
    if (immIn) begin
      val2 = rotr({24'd0, shiftOperand[7:0]}, {shiftOperand[11:8], 1'b0});
    end else if (memAccess) begin
      val2 = {20'd0, shiftOperand};
    end else if (shAmt_s == 5'd0) begin
      // Zero amount passes Rm through for every type (no RRX).
      val2 = rmFwd;
    end else begin
      case (shiftOperand[6:5])
        SH_LSL:  val2 = rmFwd << shAmt_s;
        SH_LSR:  val2 = rmFwd >> shAmt_s;
        SH_ASR:  val2 = $unsigned($signed(rmFwd) >>> shAmt_s);
        SH_ROR:  val2 = rotr(rmFwd, shAmt_s);
        default: val2 = rmFwd;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM-subset pipeline.
// Forwards Rn/Rm, builds Val2, runs the ALU, computes the branch target and
// holds the NZCV status register read by the decode-stage condition check.
// Ports: clk/rst (sync active-high); ID/EX fields pcIn, aluCmdIn, memReadIn,
// memWriteIn, sIn, immIn, shiftOperandIn, imm24In, regRnIn, regRmIn;
// forwarding selSrc1/selSrc2, memFwdVal, wbFwdVal; outputs aluResOut,
// storeValOut, branchAddrOut (combinational) and statusOut (registered).
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcIn,
  input  logic [3:0]  aluCmdIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic        sIn,
  input  logic        immIn,
  input  logic [11:0] shiftOperandIn,
  input  logic [23:0] imm24In,
  input  logic [31:0] regRnIn,
  input  logic [31:0] regRmIn,
  input  logic [1:0]  selSrc1,
  input  logic [1:0]  selSrc2,
  input  logic [31:0] memFwdVal,
  input  logic [31:0] wbFwdVal,
  output logic [31:0] aluResOut,
  output logic [31:0] storeValOut,
  output logic [31:0] branchAddrOut,
  output logic [3:0]  statusOut
);

  logic [31:0] op1_s;
  logic [31:0] rmFwd_s;
  logic [31:0] val2_s;
  logic [3:0]  aluFlags_s;

  // Rn forwarding mux.
  always_comb begin
    op1_s = regRnIn;
    case (selSrc1)
      FWD_MEM:  op1_s = memFwdVal;
      FWD_WB:   op1_s = wbFwdVal;
      default:  op1_s = regRnIn;
    endcase
  end

  // Rm forwarding mux; also the store data.
  always_comb begin
    rmFwd_s = regRmIn;
    case (selSrc2)
      FWD_MEM:  rmFwd_s = memFwdVal;
      FWD_WB:   rmFwd_s = wbFwdVal;
      default:  rmFwd_s = regRmIn;
    endcase
  end

  assign storeValOut = rmFwd_s;

  exe_stage_val2_gen uVal2 (
    .immIn        (immIn),
    .memAccess    (memReadIn | memWriteIn),
    .shiftOperand (shiftOperandIn),
    .rmFwd        (rmFwd_s),
    .val2         (val2_s)
  );

  exe_stage_alu uAlu (
    .aluCmd (aluCmdIn),
    .op1    (op1_s),
    .val2   (val2_s),
    .cIn    (statusOut[FLAG_C]),
    .result (aluResOut),
    .flags  (aluFlags_s)
  );

  // Word offset sign-extended and scaled to bytes.
  assign branchAddrOut = pcIn + {{6{imm24In[23]}}, imm24In, 2'b00};

  Register #(.W(SR_W)) uStatus (
    .clk (clk),
    .rst (rst),
    .ld  (sIn),
    .clr (1'b0),
    .d   (aluFlags_s),
    .q   (statusOut)
  );

endmodule
